// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks a 4-input combinational block through all 16 input
// vectors. Each vector is held for SETTLE_CYCLES and then observed for
// SAMPLE_CYCLES, and the response is recorded into a 16-bit truth table.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          synchronous active-high reset
//   start        request a full 16-vector sweep (honoured only in IDLE)
//   abort        cancel a sweep that is settling or sampling
//   a,b,c,d      drive the logic under test: {a,b,c,d} = idx while busy, else 0
//   sense        response of the logic under test
//   busy         high while settling or sampling
//   done         one-cycle pulse when a sweep completes
//   aborted      one-cycle pulse when a sweep is cancelled
//   truth_table  bit i = response to vector i (the obvious name, table, is a
//                reserved word)
//   unstable     bit i = sense moved while vector i was being sampled
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  input  logic        sense,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [15:0] truth_table,
  output logic [15:0] unstable
);

  localparam int unsigned MAX_CYC = (SETTLE_CYCLES > SAMPLE_CYCLES) ?
                                    SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     table_d, unstable_d;
  logic            aborted_d;
  logic            busy_d;
  logic            done_d;
  logic [3:0]      drive_d;

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      cnt_q       <= '0;
      truth_table <= 16'd0;
      unstable    <= 16'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      {a, b, c, d} <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      truth_table <= table_d;
      unstable    <= unstable_d;
      busy        <= busy_d;
      done        <= done_d;
      aborted     <= aborted_d;
      {a, b, c, d} <= drive_d;
    end
  end

  // Next state, sweep bookkeeping and next output values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    table_d    = truth_table;
    unstable_d = unstable;
    aborted_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          table_d    = 16'd0;
          unstable_d = 16'd0;
          idx_d      = 4'd0;
          cnt_d      = '0;
          state_d    = SETTLE;
        end
      end

      SETTLE: begin
        if (abort) begin
          cnt_d     = '0;
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      SAMPLE: begin
        if (abort) begin
          cnt_d     = '0;
          aborted_d = 1'b1;
          state_d   = IDLE;
        end else begin
          // First sample defines the table bit; later samples only flag drift.
          if (cnt_q == '0) begin
            table_d[idx_q] = sense;
          end else if (sense != truth_table[idx_q]) begin
            unstable_d[idx_q] = 1'b1;
          end
          if (cnt_q == SAMPLE_LAST) begin
            cnt_d = '0;
            if (idx_q == 4'd15) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = SETTLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    busy_d  = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d  = (state_d == DONE);
    drive_d = busy_d ? idx_d : 4'd0;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 8: cycles each input vector is held before sampling; legal range >= 1.
REQ-002 SHALL have parameter SAMPLE_CYCLES, default 4: cycles the sense input is observed per vector; legal range >= 1.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: requests a full 16-vector sweep.
REQ-006 SHALL have port abort, input, 1: cancels a sweep in progress.
REQ-007 SHALL have ports a, b, c, d, output, 1 each: drive the four inputs of the downstream 4-input logic under test.
REQ-008 SHALL have port sense, input, 1: the output of the logic under test.
REQ-009 SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when a sweep completes.
REQ-011 SHALL have port aborted, output, 1: one-cycle pulse when a sweep is cancelled.
REQ-012 SHALL have port table, output, 16: measured truth table; bit i is the response to vector i.
REQ-013 SHALL have port unstable, output, 16: bit i is set when sense changed during sampling of vector i.

Function
REQ-014 SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE, with a 4-bit vector index idx.
REQ-015 SHALL, in IDLE with start=1 and abort=0, clear table and unstable, set idx=0 and enter SETTLE on the next cycle; start SHALL be ignored in all other states.
REQ-016 SHALL drive a=idx[3], b=idx[2], c=idx[1], d=idx[0] in SETTLE and SAMPLE, and drive a=b=c=d=0 in IDLE and DONE.
REQ-017 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-018 SHALL remain in SAMPLE for exactly SAMPLE_CYCLES cycles.
REQ-019 SHALL load table[idx] with the value of sense in the first SAMPLE cycle.
REQ-020 SHALL set unstable[idx] in any later SAMPLE cycle of the same vector where sense differs from that first value.
REQ-021 SHALL, at the end of SAMPLE, enter DONE if idx=15; otherwise it SHALL increment idx and enter SETTLE.
REQ-022 SHALL keep DONE for one cycle with done=1 and then return to IDLE; table and unstable SHALL hold until the next accepted start or reset.
REQ-023 SHALL assert busy exactly in SETTLE and SAMPLE.
REQ-024 SHALL give sweep latency as follows: with start accepted at edge 0, done is high in cycle 16*(SETTLE_CYCLES+SAMPLE_CYCLES)+1.
REQ-025 SHALL, when abort=1 in SETTLE or SAMPLE, enter IDLE on the next edge and pulse aborted for one cycle; done SHALL NOT assert and table/unstable SHALL retain their partial contents.
REQ-026 SHALL give abort no effect in IDLE and DONE; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-027 SHALL size the settle/sample counter to ceil(log2(max(SETTLE_CYCLES,SAMPLE_CYCLES)+1)) bits, with no wrap within a phase.

Reset
REQ-028 SHALL, with rst=1 on a clock edge, enter IDLE and clear idx, counters, a, b, c, d, busy, done, aborted, table and unstable to 0.
REQ-029 SHALL give rst priority over start and abort, including mid-sweep, with no done or aborted pulse.

Verification (SETTLE_CYCLES=2, SAMPLE_CYCLES=2)
REQ-030 SHALL be verified with sense = a&b&c&d (4-input AND model): start -> done in cycle 65, table=16'h8000, unstable=16'h0000.
REQ-031 SHALL be verified with sense tied to 1: full sweep -> table=16'hFFFF, unstable=0; busy high in cycles 1-64 and low in cycle 65.
REQ-032 SHALL be verified with the AND model and sense toggled in the second SAMPLE cycle of vector 6: unstable=16'h0040, table bit 6 = 0.
REQ-033 SHALL be verified with abort asserted while idx=5 -> aborted pulse, IDLE next cycle, no done, table bits 0-4 valid, a=b=c=d=0.
REQ-034 SHALL be verified with start re-asserted during a sweep and then rst at idx=9 -> the re-assertion is ignored (idx progression unchanged) and after rst all outputs are 0 and state is IDLE.
